// File: rtl/led_share_pkg.sv
// led_share_pkg: shared types and helpers for the LED sharing scheduler.
//   state_e        scheduler FSM states
//   Off{R,G,B}     slice offsets (in units of PWM_BITS) of each channel in a colour word
//   rr_pick()      round-robin one-hot selection starting at rr_ptr, with wrap
package led_share_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShow    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam int unsigned MaxReq = 8;

  // Colour word is {R,G,B} with R in the MSBs.
  localparam int unsigned OffR = 2;
  localparam int unsigned OffG = 1;
  localparam int unsigned OffB = 0;

  // First set bit of req at or above rr_ptr, wrapping at n_req. Zero if req is empty.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input logic [2:0]        rr_ptr,
                                                input int unsigned       n_req);
    logic [MaxReq-1:0] pick;
    logic              found;
    logic [2:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = 3'((32'(rr_ptr) + i) % n_req);
      if (i < n_req && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_share_sched_pwm.sv
// led_pwm: per-channel PWM dimming with registered active-low LED drives.
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_enable              low forces all LEDs off
//   i_int_r/g/b           channel intensities; channel lit while pwm_cnt < intensity
//   o_led_r/g/b           active-low LED drives (0 = lit)
module led_pwm #(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_int_r,
  input  logic [PWM_BITS-1:0] i_int_g,
  input  logic [PWM_BITS-1:0] i_int_b,
  output logic                o_led_r,
  output logic                o_led_g,
  output logic                o_led_b
);

  logic [PWM_BITS-1:0] r_pwm_cnt;

  // Free-running; never re-phased on a new grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      o_led_r   <= 1'b1;
      o_led_g   <= 1'b1;
      o_led_b   <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      o_led_r   <= ~(i_enable && (r_pwm_cnt < i_int_r));
      o_led_g   <= ~(i_enable && (r_pwm_cnt < i_int_g));
      o_led_b   <= ~(i_enable && (r_pwm_cnt < i_int_b));
    end
  end

endmodule

// File: rtl/led_share_sched.sv
// led_share_sched: round-robin sharing of one RGB LED between N_REQ requesters.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_req          per-requester request level
//   i_color        requester i colour at slice i, {R,G,B} with R in MSBs
//   i_dwell        requester i dwell in prescaler ticks; 0 holds until req drops
//   o_gnt          registered one-hot grant
//   o_done         one-cycle pulse on the tick that completes a dwell
//   o_led_r/g/b    registered active-low LED drives
module led_share_sched
  import led_share_pkg::*;
#(
  parameter int unsigned N_REQ         = 3,
  parameter int unsigned PWM_BITS      = 4,
  parameter int unsigned DWELL_BITS    = 8,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*3*PWM_BITS-1:0] i_color,
  input  logic [N_REQ*DWELL_BITS-1:0] i_dwell,
  output logic [N_REQ-1:0]            o_gnt,
  output logic                        o_done,
  output logic                        o_led_r,
  output logic                        o_led_g,
  output logic                        o_led_b
);

  localparam int unsigned ColW = 3 * PWM_BITS;
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                   r_state, w_state_d;
  logic [N_REQ-1:0]         r_gnt, w_gnt_d;
  logic [IdxW-1:0]          r_idx, w_idx_d;
  logic [IdxW-1:0]          r_rr_ptr, w_rr_ptr_d;
  logic [ColW-1:0]          r_color, w_color_d;
  logic [DWELL_BITS-1:0]    r_dwell, w_dwell_d;
  logic [DWELL_BITS-1:0]    r_dwell_cnt, w_dwell_cnt_d;
  logic [PRESCALE_BITS-1:0] r_presc;

  logic [MaxReq-1:0]        w_pick_full;
  logic [N_REQ-1:0]         w_pick;
  logic [IdxW-1:0]          w_pick_idx;
  logic                     w_tick;
  logic                     w_owner_req;
  logic                     w_dwell_done;
  logic                     w_unused_pick;

  assign w_pick_full   = rr_pick(MaxReq'(i_req), 3'(r_rr_ptr), N_REQ);
  assign w_pick        = w_pick_full[N_REQ-1:0];
  assign w_unused_pick = ^w_pick_full;

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = IdxW'(i);
    end
  end

  assign w_tick       = &r_presc;
  assign w_owner_req  = |(i_req & r_gnt);
  // A zero dwell never loads a 1 into the counter, so it can only end by abort.
  assign w_dwell_done = w_tick && (r_dwell != '0) && (r_dwell_cnt == DWELL_BITS'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_idx       <= '0;
      r_rr_ptr    <= '0;
      r_color     <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_idx       <= w_idx_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_color     <= w_color_d;
      r_dwell     <= w_dwell_d;
      r_dwell_cnt <= w_dwell_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_gnt_d       = r_gnt;
    w_idx_d       = r_idx;
    w_rr_ptr_d    = r_rr_ptr;
    w_color_d     = r_color;
    w_dwell_d     = r_dwell;
    w_dwell_cnt_d = r_dwell_cnt;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_d     = StShow;
          w_gnt_d       = w_pick;
          w_idx_d       = w_pick_idx;
          // Snapshot so later input changes cannot disturb the current dwell.
          w_color_d     = i_color[w_pick_idx*ColW +: ColW];
          w_dwell_d     = i_dwell[w_pick_idx*DWELL_BITS +: DWELL_BITS];
          w_dwell_cnt_d = i_dwell[w_pick_idx*DWELL_BITS +: DWELL_BITS];
        end
      end
      StShow: begin
        if (w_dwell_done || !w_owner_req) begin
          w_state_d = StRelease;
          w_gnt_d   = '0;
        end else if (w_tick && (r_dwell != '0)) begin
          w_dwell_cnt_d = r_dwell_cnt - DWELL_BITS'(1);
        end
      end
      StRelease: begin
        w_state_d  = StIdle;
        w_rr_ptr_d = (r_idx == IdxW'(N_REQ - 1)) ? '0 : r_idx + IdxW'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_gnt  = r_gnt;
  // Coincides with the tick edge that leaves SHOW; also wins over a same-cycle abort.
  assign o_done = (r_state == StShow) && w_dwell_done;

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_enable(r_state == StShow),
    .i_int_r (r_color[OffR*PWM_BITS +: PWM_BITS]),
    .i_int_g (r_color[OffG*PWM_BITS +: PWM_BITS]),
    .i_int_b (r_color[OffB*PWM_BITS +: PWM_BITS]),
    .o_led_r (o_led_r),
    .o_led_g (o_led_g),
    .o_led_b (o_led_b)
  );

endmodule

// File: tb/tb_led_share_sched.sv
// Bench for led_share_sched: directed sequences, an arbitration vector table and a
// randomized run checked against a transaction-level reference model.
module tb_led_share_sched;

  localparam int unsigned N   = 3;
  localparam int unsigned PB  = 4;
  localparam int unsigned DB  = 8;
  localparam int unsigned PSB = 4;
  localparam int unsigned CW  = 3 * PB;
  localparam int unsigned TMAX = (1 << PSB) - 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] color;
  logic [N*DB-1:0] dwell;
  logic [N-1:0]    gnt;
  logic            done;
  logic            led_r, led_g, led_b;

  int          vectors;
  int          miscompares;
  int unsigned cyc;

  led_share_sched #(
    .N_REQ        (N),
    .PWM_BITS     (PB),
    .DWELL_BITS   (DB),
    .PRESCALE_BITS(PSB)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_color(color),
    .i_dwell(dwell),
    .o_gnt  (gnt),
    .o_done (done),
    .o_led_r(led_r),
    .o_led_g(led_g),
    .o_led_b(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the tick falls where this is all-ones mod 2^PSB.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic [N-1:0] prior;
    logic [N-1:0] req;
    logic [N-1:0] exp_gnt;
  } arb_vec_t;

  arb_vec_t arb_tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, event never seen (t=%0t)", name, $time);
  endtask

  task automatic set_col(input int i, input logic [CW-1:0] c);
    color[i*CW +: CW] = c;
  endtask

  task automatic set_dw(input int i, input logic [DB-1:0] d);
    dwell[i*DB +: DB] = d;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    color = '0;
    dwell = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [N-1:0] g, input string name);
    g = '0;
    for (int k = 0; k < 300; k++) begin
      if (gnt != '0) begin
        g = gnt;
        return;
      end
      @(negedge clk);
    end
    note_timeout(name);
  endtask

  task automatic wait_release(input string name);
    for (int k = 0; k < 300; k++) begin
      if (gnt == '0) return;
      @(negedge clk);
    end
    note_timeout(name);
  endtask

  task automatic run_random(input int ncyc);
    int              owner;
    int              gap;
    int              ptr;
    int              presc;
    int              ticks;
    int              dwl;
    int              fl;
    logic [CW-1:0]   col;
    logic [2:0]      exp_led;
    logic            exp_done;
    logic [N-1:0]    exp_gnt;
    owner   = -1;
    gap     = 0;
    ptr     = 0;
    presc   = 0;
    ticks   = 0;
    dwl     = 0;
    col     = '0;
    exp_led = 3'b111;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      exp_gnt = '0;
      if (owner >= 0) exp_gnt[owner] = 1'b1;
      exp_done = (owner >= 0) && (dwl != 0) && (ticks == 1) && (presc == int'(TMAX));
      check("rand_gnt", 32'(gnt), 32'(exp_gnt));
      check("rand_done", 32'(done), 32'(exp_done));
      check("rand_led", 32'({led_r, led_g, led_b}), 32'(exp_led));
      // New stimulus for the coming edge.
      if ($urandom_range(5) == 0) begin
        fl = int'($urandom_range(N - 1));
        req[fl] = ~req[fl];
      end
      for (int i = 0; i < int'(N); i++) begin
        set_col(i, CW'($urandom));
        set_dw(i, DB'($urandom_range(3)));
      end
      // Reference model: what the coming edge should do.
      for (int k = 0; k < 3; k++) begin
        exp_led[2-k] = !((owner >= 0) && ((presc % (1 << PB)) < int'(col[(2-k)*PB +: PB])));
      end
      if (owner >= 0) begin
        if (exp_done || !req[owner]) begin
          ptr   = (owner + 1) % int'(N);
          owner = -1;
          gap   = 1;
        end else if (presc == int'(TMAX) && dwl != 0) begin
          ticks--;
        end
      end else if (gap > 0) begin
        gap--;
      end else if (req != '0) begin
        for (int k = 0; k < int'(N); k++) begin
          int idx;
          idx = (ptr + k) % int'(N);
          if (req[idx]) begin
            owner = idx;
            col   = color[idx*CW +: CW];
            dwl   = int'(dwell[idx*DB +: DB]);
            ticks = dwl;
            break;
          end
        end
      end
      presc = (presc + 1) % (1 << PSB);
      @(negedge clk);
    end
  endtask

  logic [N-1:0] g;
  logic [N-1:0] order[4];
  int s, nr, ng, nb, ticks, dcount, dtick, don_tick, bad, n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    arb_tbl[0] = '{prior: 3'b000, req: 3'b001, exp_gnt: 3'b001};
    arb_tbl[1] = '{prior: 3'b000, req: 3'b110, exp_gnt: 3'b010};
    arb_tbl[2] = '{prior: 3'b000, req: 3'b100, exp_gnt: 3'b100};
    arb_tbl[3] = '{prior: 3'b001, req: 3'b101, exp_gnt: 3'b100};
    arb_tbl[4] = '{prior: 3'b001, req: 3'b001, exp_gnt: 3'b001};
    arb_tbl[5] = '{prior: 3'b010, req: 3'b011, exp_gnt: 3'b001};
    arb_tbl[6] = '{prior: 3'b100, req: 3'b110, exp_gnt: 3'b010};
    arb_tbl[7] = '{prior: 3'b010, req: 3'b110, exp_gnt: 3'b100};
    arb_tbl[8] = '{prior: 3'b100, req: 3'b111, exp_gnt: 3'b001};
    order = '{3'b001, 3'b010, 3'b100, 3'b001};

    // Reset state, sampled while reset is held.
    rst = 1'b1; req = '0; color = '0; dwell = '0;
    repeat (2) @(negedge clk);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_done", 32'(done), 0);
    check("reset_led", 32'({led_r, led_g, led_b}), 32'h7);
    rst = 1'b0;

    // Single requester, R=F G=0 B=8, dwell 2.
    set_col(0, 12'hF08); set_dw(0, 2); req = 3'b001;
    @(negedge clk);
    check("t1_grant_latency", 32'(gnt), 1);
    s = 0; nr = 0; ng = 0; nb = 0; ticks = 0; dcount = 0; dtick = 0; don_tick = 0;
    while (gnt == 3'b001 && s < 200) begin
      if (s >= 1 && s <= 16) begin
        nr += led_r ? 0 : 1;
        ng += led_g ? 0 : 1;
        nb += led_b ? 0 : 1;
      end
      if (cyc % (1 << PSB) == TMAX) ticks++;
      if (done) begin
        dcount++;
        dtick    = ticks;
        don_tick = (cyc % (1 << PSB) == TMAX) ? 1 : 0;
      end
      s++;
      @(negedge clk);
    end
    check("t1_duty_r", nr, 15);
    check("t1_duty_g", ng, 0);
    check("t1_duty_b", nb, 8);
    check("t1_done_count", dcount, 1);
    check("t1_done_tick_no", dtick, 2);
    check("t1_done_on_tick", don_tick, 1);
    check("t1_release_gnt", 32'(gnt), 0);
    check("t1_release_done", 32'(done), 0);
    @(negedge clk);
    check("t1_idle_gnt", 32'(gnt), 0);
    @(negedge clk);
    check("t1_regrant", 32'(gnt), 1);

    // All three requesting, dwell 1: strict rotation, one done each.
    do_reset();
    for (int i = 0; i < int'(N); i++) set_dw(i, 1);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, "t2_grant");
      check("t2_order", 32'(g), 32'(order[k]));
      dcount = 0; n = 0;
      while (gnt != '0 && n < 100) begin
        if (done) dcount++;
        n++;
        @(negedge clk);
      end
      check("t2_done_per_grant", dcount, 1);
    end

    // Dwell 0 holds until req drops; abort gives no done.
    do_reset();
    set_col(0, 12'hF08); set_dw(0, 0); req = 3'b001;
    wait_grant(g, "t3_grant");
    check("t3_grant", 32'(g), 1);
    bad = 0; dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (gnt != 3'b001) bad++;
      if (done) dcount++;
    end
    check("t3_held", bad, 0);
    check("t3_no_done_held", dcount, 0);
    req = '0;
    @(negedge clk);
    check("t3_abort_gnt", 32'(gnt), 0);
    check("t3_abort_done", 32'(done), 0);
    @(negedge clk);
    check("t3_leds_off", 32'({led_r, led_g, led_b}), 32'h7);

    // Colour change mid-dwell is ignored until the next grant.
    do_reset();
    set_col(0, 12'h400); set_dw(0, 5); req = 3'b001;
    wait_grant(g, "t4_grant");
    repeat (20) @(negedge clk);
    set_col(0, 12'hFFF);
    nr = 0; ng = 0;
    repeat (16) begin
      @(negedge clk);
      nr += led_r ? 0 : 1;
      ng += led_g ? 0 : 1;
    end
    check("t4_latched_r", nr, 4);
    check("t4_latched_g", ng, 0);
    wait_release("t4_release");
    wait_grant(g, "t4_regrant");
    nr = 0;
    repeat (16) begin
      @(negedge clk);
      nr += led_r ? 0 : 1;
    end
    check("t4_new_colour_r", nr, 15);

    // Asynchronous reset mid-dwell clears rr_ptr.
    do_reset();
    set_col(0, 12'hF08); set_dw(0, 4); set_dw(1, 1); req = 3'b010;
    wait_grant(g, "t5_first");
    wait_release("t5_release");
    req = 3'b001;
    wait_grant(g, "t5_second");
    check("t5_second", 32'(g), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_gnt", 32'(gnt), 0);
    check("t5_async_done", 32'(done), 0);
    check("t5_async_led", 32'({led_r, led_g, led_b}), 32'h7);
    @(negedge clk);
    req = 3'b110;
    rst = 1'b0;
    wait_grant(g, "t5_after_reset");
    check("t5_after_reset", 32'(g), 2);

    // Zero intensity: never lit, done still pulses.
    do_reset();
    set_col(0, 12'h000); set_dw(0, 3); req = 3'b001;
    wait_grant(g, "t6_grant");
    nr = 0; dcount = 0; n = 0;
    while (gnt == 3'b001 && n < 200) begin
      nr += (led_r && led_g && led_b) ? 0 : 1;
      if (done) dcount++;
      n++;
      @(negedge clk);
    end
    nr += (led_r && led_g && led_b) ? 0 : 1;
    check("t6_never_lit", nr, 0);
    check("t6_done", dcount, 1);

    // Arbitration table: optional prior grant sets rr_ptr, then check the next pick.
    for (int t = 0; t < 9; t++) begin
      do_reset();
      for (int i = 0; i < int'(N); i++) set_dw(i, 1);
      if (arb_tbl[t].prior != '0) begin
        req = arb_tbl[t].prior;
        wait_grant(g, "arb_prior");
        check("arb_prior", 32'(g), 32'(arb_tbl[t].prior));
        req = arb_tbl[t].req;
        wait_release("arb_release");
      end else begin
        req = arb_tbl[t].req;
      end
      wait_grant(g, "arb_grant");
      check("arb_grant", 32'(g), 32'(arb_tbl[t].exp_gnt));
    end

    run_random(4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Round-robin scheduler that shares the board RGB LED between up to N_REQ requesters. Each requester presents a 12-bit colour (4-bit R/G/B intensity) and a dwell time. The scheduler grants one requester at a time, drives the LED with per-channel PWM dimming for the dwell period, then releases it and moves to the next requester. It sits between the status/pattern producers and the LED pins, replacing direct free-running counter drive of the LEDs.

## Interface
- N_REQ, 3: number of requesters (2..8)
- PWM_BITS, 4: intensity/PWM resolution per channel
- DWELL_BITS, 8: dwell field width, in ticks
- PRESCALE_BITS, 16: tick period = 2^PRESCALE_BITS clk cycles
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level
- color  in  N_REQ*3*PWM_BITS  requester i at slice i; within a slice {R,G,B}, R in MSBs
- dwell  in  N_REQ*DWELL_BITS  requester i dwell in ticks; 0 = hold until req drops
- gnt  out  N_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse when a dwell completes normally
- led_r, led_g, led_b  out  1 each  active-low LED drives (0 = lit), registered

## Operation
- Free-running PRESCALE_BITS prescaler; `tick` = prescaler all-ones. Free-running PWM_BITS counter `pwm_cnt`.
- FSM states: IDLE, SHOW, RELEASE.
- IDLE: if any req, select the first set bit searching upward from `rr_ptr` with wrap; next cycle in SHOW, gnt = that one-hot, latch colour and dwell into local registers, `dwell_cnt` = dwell.
- SHOW: channel c lit iff pwm_cnt < latched intensity c. Intensity 0 is never lit; max is lit (2^PWM_BITS-1)/2^PWM_BITS of the time.
- SHOW, dwell != 0: decrement dwell_cnt on each tick; on the tick where dwell_cnt == 1, pulse done and go to RELEASE.
- SHOW, granted req deasserts (any dwell): abort to RELEASE, no done. If abort and completion coincide, done is pulsed.
- Inputs change while granted: ignored; the latched colour and dwell are used.
- RELEASE (one cycle): gnt = 0, LEDs off, rr_ptr = granted index + 1 mod N_REQ, then IDLE.
- Not in SHOW: all LEDs off (1).
- Reset (asynchronous, any time): state IDLE, gnt = 0, done = 0, led_* = 1, rr_ptr = 0, dwell_cnt = 0, prescaler = 0, pwm_cnt = 0. Requester 0 has first priority after reset.

## Timing
- req sampled in IDLE at edge k -> gnt valid and SHOW entered at edge k+1; LED outputs reflect PWM one cycle after the internal compare (registered).
- Minimum gap between grants: RELEASE + IDLE = 2 cycles of gnt low.
- Dwell duration: first tick after grant counts as tick 1, so SHOW lasts dwell-1 full tick periods plus the fraction up to the first tick. The bench checks tick counts, not exact cycles.
- done asserted for exactly one cycle, coincident with the tick edge that ends SHOW; gnt drops the following cycle.
- PWM period 2^PWM_BITS cycles, free-running and not re-phased on grant.

## Structure
- Package `led_share_pkg`: FSM state enum, R/G/B slice offsets, and function `rr_pick(req, rr_ptr)` returning the one-hot grant.
- Sub-module `led_pwm`: pwm_cnt, three compares, registered active-low outputs, `enable` input (low forces off). FSM, prescaler and arbitration stay in the top.

## Test plan
Bench uses PRESCALE_BITS=4, PWM_BITS=4, N_REQ=3.
- Reset, then req=3'b001, colour0 R=F,G=0,B=8, dwell0=2 -> gnt=001 one cycle later; led_g stays 1; led_r low 15/16, led_b low 8/16 of cycles; done after the 2nd tick; then 2 cycles of gnt=0.
- req=3'b111 held, all dwell=1 -> grant order 001,010,100,001, one done per grant.
- req0 with dwell=0, drop req0 after 40 cycles -> gnt0 drops in RELEASE the cycle after, no done pulse, LEDs off.
- Change color0 mid-SHOW -> LED duty unchanged until the next grant.
- Assert rst mid-SHOW, asynchronously between edges -> gnt=0, led_*=1 immediately; after release with req=3'b110, gnt=010 is granted first (rr_ptr=0).
- Intensity 0 on all channels, dwell=3 -> led_* stay 1 throughout, done still pulses.
